muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Iterative multiply/divide unit with architectural HI/LO registers.
//   Sits downstream of the register file and consumes its two read ports (rd1 -> a, rd2 -> b)
//   for MULT/MULTU/DIV/DIVU.
//   Serves MFHI/MFLO reads and MTHI/MTLO writes.
//   Raises busy so the control path stalls HI/LO consumers until the result is ready.
// PARAMETERS
//   WIDTH   32   operand width; HI and LO are each WIDTH bits.
//   CNT_W   6    iteration counter width; must satisfy 2**CNT_W > WIDTH.
// PORTS
//   clk     in   1      clock; all state changes on posedge.
//   reset   in   1      synchronous, active-high reset.
//   start   in   1      launch operation; sampled only when busy==0.
//   op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
//   a       in   WIDTH  multiplicand / dividend (register file rd1).
//   b       in   WIDTH  multiplier / divisor (register file rd2).
//   we_hi   in   1      MTHI write enable.
//   we_lo   in   1      MTLO write enable.
//   wd      in   WIDTH  MTHI/MTLO write data.
//   busy    out  1      operation in progress.
//   done    out  1      one-cycle pulse; result visible on hi/lo in this cycle.
//   hi      out  WIDTH  HI register (product[2W-1:W] or remainder).
//   lo      out  WIDTH  LO register (product[W-1:0] or quotient).
// BEHAVIOUR
//   Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
//     Reset overrides every other input in the same cycle.
//   Reset during CALC/FIX aborts the operation; the partial result is discarded.
//   FSM: IDLE -> CALC on start&&!busy. CALC -> FIX after WIDTH iterations. FIX -> IDLE.
//   Launch edge: a, b and op are latched.
//     Signed ops (MULT, DIV) store |a| and |b|, plus the result-sign flags:
//       product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
//   CALC: one iteration per clock for exactly WIDTH cycles.
//     MUL: radix-2 shift-add into a 2*WIDTH accumulator.
//     DIV: restoring shift-subtract, one quotient bit per cycle.
//   FIX: apply two's-complement sign correction, then write hi/lo on this edge.
//   busy: 1 from the cycle after launch through the FIX cycle.
//   Latency: start sampled at edge E0; hi/lo updated at edge E(WIDTH+1).
//     done=1 and busy=0 for exactly the one cycle following that edge.
//   A new start in the done cycle is accepted (back-to-back operations).
//   start while busy=1 is ignored (not queued).
//   hi/lo hold their previous values throughout CALC; they change only at FIX.
//   Divide by zero, both DIV and DIVU: lo=all ones, hi=a as supplied (unmodified).
//   Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//   MTHI/MTLO:
//     - When busy=0, write wd into hi/lo at the next edge; we_hi and we_lo may both be set.
//     - When busy=1, writes are dropped.
//     - In the launch cycle (start && !busy), start wins and the write is dropped.
//   All arithmetic is modulo 2**WIDTH per half; no flags and no exceptions.
// TESTING
//   MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done at cycle 33; busy for 32 cycles before it.
//   MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//   DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
//   Divide by zero and overflow:
//     DIVU 0x64/0 -> lo=0xFFFFFFFF, hi=0x64.
//     DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//   Busy and write handling, with hi=lo=0x11111111 held before launch:
//     start plus we_hi during busy -> ignored; hi/lo stay 0x11111111 until FIX.
//     MTLO 0xABCD when idle -> lo=0xABCD next cycle.
//   Reset at cycle 10 of a DIV -> next cycle busy=0, done=0, hi=lo=0.
//     A new MULTU 3*5 then completes: lo=15, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add or shift-subtract step per clock; sign correction in a final FIX cycle.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    // state | meaning
    // IDLE  | waiting for start; MTHI/MTLO writes accepted
    // CALC  | one multiply/divide iteration per cycle, WIDTH cycles
    // FIX   | sign correction, hi/lo written on the closing edge
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_raw;
    logic               is_div, neg_q, neg_r, b_zero;

    logic               launch, signed_op;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;
    logic [WIDTH-1:0]   quo, rem;

    assign busy      = (state != IDLE);
    assign launch    = start && (state == IDLE);
    assign signed_op = ~op[0];
    assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

    // Multiply: accumulator upper half gathers partial sums, lower half shifts out the multiplier.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
    assign div_sh   = acc[2*WIDTH-1:WIDTH-1];
    assign div_ge   = (div_sh >= {1'b0, opnd});
    assign div_diff = div_sh - {1'b0, opnd};
    assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

    assign prod = neg_q ? -acc : acc;
    assign quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            a_raw  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= (state == FIX);
            if (launch) begin
                cnt    <= CNT_W'(WIDTH - 1);
                is_div <= op[1];
                neg_q  <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r  <= signed_op && a[WIDTH-1];
                b_zero <= (b == '0);
                a_raw  <= a;
                acc    <= op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                opnd   <= op[1] ? b_mag : a_mag;
            end else if (state == IDLE) begin
                if (we_hi) hi <= wd;
                if (we_lo) lo <= wd;
            end else if (state == CALC) begin
                cnt <= cnt - 1'b1;
                acc <= is_div ? div_next : mul_next;
            end else if (state == FIX) begin
                if (is_div && b_zero) begin
                    hi <= a_raw;
                    lo <= '1;
                end else if (is_div) begin
                    hi <= rem;
                    lo <= quo;
                end else begin
                    hi <= prod[2*WIDTH-1:WIDTH];
                    lo <= prod[WIDTH-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected HI/LO pairs queued at launch, popped on done.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0, b = '0, wd = '0;
    logic         we_hi = 1'b0, we_lo = 1'b0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;
    res_t sb[$];

    int total = 0;
    int bad = 0;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .we_hi(we_hi), .we_lo(we_lo), .wd(wd),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a launch in the current cycle, take the edge, then release start.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] eh, input logic [W-1:0] el);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sb.push_back('{hi: eh, lo: el});
        chk("busy_after_launch", {31'b0, busy}, 32'd1);
    endtask

    // Wait for done with a cycle budget; returns edges counted after launch and whether busy held.
    task automatic wait_done(output int n, output logic busy_ok);
        n = 0;
        busy_ok = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (done) begin
                n = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic check_result(input string tag);
        res_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_hi"}, hi, e.hi);
            chk({tag, "_lo"}, lo, e.lo);
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el);
        int n;
        logic bok;
        launch(o, x, y, eh, el);
        wait_done(n, bok);
        chk({tag, "_latency"}, n, W + 1);
        chk({tag, "_busy_off_at_done"}, {31'b0, busy}, 32'd0);
        check_result(tag);
    endtask

    initial begin
        int n;
        logic bok;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);

        launch(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        wait_done(n, bok);
        chk("mult_latency", n, W + 1);
        chk("mult_busy_held", {31'b0, bok}, 32'd1);
        chk("mult_busy_off_at_done", {31'b0, busy}, 32'd0);
        check_result("mult");
        @(posedge clk); #1;
        chk("done_one_cycle", {31'b0, done}, 32'd0);

        run("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        run("divu_by0", 2'b11, 32'h64, 32'd0, 32'h64, 32'hFFFF_FFFF);
        run("div_by0_neg", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // Seed HI/LO, then check a launch-cycle write and a busy-time start/write are dropped.
        wd = 32'h1111_1111; we_hi = 1'b1; we_lo = 1'b1;
        @(posedge clk); #1;
        we_hi = 1'b0; we_lo = 1'b0;
        chk("mt_both_hi", hi, 32'h1111_1111);
        chk("mt_both_lo", lo, 32'h1111_1111);

        wd = 32'hDEAD_BEEF; we_hi = 1'b1;
        launch(2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        bok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (hi !== 32'h1111_1111 || lo !== 32'h1111_1111) bok = 1'b0;
        end
        start = 1'b0; we_hi = 1'b0;
        chk("hold_during_busy", {31'b0, bok}, 32'd1);
        wait_done(n, bok);
        chk("held_op_done", {31'b0, done}, 32'd1);
        check_result("held_op");
        repeat (3) @(posedge clk);
        #1;
        chk("busy_start_not_queued", {31'b0, busy}, 32'd0);

        wd = 32'h0000_ABCD; we_lo = 1'b1;
        @(posedge clk); #1;
        we_lo = 1'b0;
        chk("mtlo_lo", lo, 32'h0000_ABCD);
        chk("mtlo_hi_kept", hi, 32'd2);

        // Back-to-back: second start issued in the done cycle of the first.
        launch(2'b01, 32'd6, 32'd7, 32'd0, 32'd42);
        wait_done(n, bok);
        check_result("b2b_first");
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1);
        wait_done(n, bok);
        chk("b2b_second_latency", n, W + 1);
        check_result("b2b_second");

        // Reset in the middle of a divide discards it.
        launch(2'b10, 32'd1000, 32'd3, 32'd1, 32'd333);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        void'(sb.pop_back());
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        chk("mid_rst_hi", hi, 32'h0);
        chk("mid_rst_lo", lo, 32'h0);
        run("after_rst_multu", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15);

        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
